// File: rtl/mar_burst_if.sv
// Bus bundle between the W bus / RAM side and the MAR.
// The slave modport is the MAR's view of the bundle.
interface mar_burst_if #(
  parameter int AW   = 4,
  parameter int BL_W = 4
);
  logic            Lm_bar;
  logic            Inc_bar;
  logic            Dec_bar;
  logic [AW-1:0]   mar_input;
  logic            burst_start;
  logic [BL_W-1:0] burst_len;
  logic            ram_ready;
  logic [AW-1:0]   mar_output;
  logic            burst_valid;
  logic            burst_busy;
  logic            burst_done;
  logic            ovf;

  modport slave (
    input  Lm_bar, Inc_bar, Dec_bar, mar_input,
    input  burst_start, burst_len, ram_ready,
    output mar_output, burst_valid, burst_busy,
    output burst_done, ovf
  );

  modport master (
    output Lm_bar, Inc_bar, Dec_bar, mar_input,
    output burst_start, burst_len, ram_ready,
    input  mar_output, burst_valid, burst_busy,
    input  burst_done, ovf
  );
endinterface

// File: rtl/mar_burst.sv
// SAP memory address register with inc/dec, wrap or
// saturate policy, sticky overflow and a burst engine.
module mar_burst #(
  parameter int            AW         = 4,
  parameter logic [AW-1:0] RESET_ADDR = {AW{1'b1}},
  parameter int            BL_W       = 4,
  parameter bit            WRAP       = 1'b1
) (
  input logic         CLK,
  input logic         CLR_bar,
  mar_burst_if.slave  bus
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;
  localparam logic [AW-1:0] ONE = AW'(1);
  localparam logic [BL_W-1:0] BONE = BL_W'(1);

  logic [AW-1:0]   addr_q, addr_d;
  logic [0:0]      state_q, state_d;
  logic [BL_W-1:0] rem_q, rem_d;
  logic            done_q, done_d;
  logic            ovf_q, ovf_d;

  logic            at_max, at_min;
  logic [AW-1:0]   addr_inc, addr_dec;

  // Step candidates; saturation holds the edge value.
  always_comb begin
    at_max   = (addr_q == {AW{1'b1}});
    at_min   = (addr_q == '0);
    addr_inc = addr_q + ONE;
    addr_dec = addr_q - ONE;
    if (at_max && !WRAP) addr_inc = addr_q;
    if (at_min && !WRAP) addr_dec = addr_q;
  end

  // Next-state: IDLE control priority and burst stepping.
  always_comb begin
    addr_d  = addr_q;
    state_d = state_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.Lm_bar) begin
          addr_d = bus.mar_input;
          ovf_d  = 1'b0;
        end else if (bus.burst_start) begin
          if (bus.burst_len != '0) begin
            rem_d   = bus.burst_len;
            state_d = BURST;
          end
        end else if (!bus.Inc_bar && bus.Dec_bar) begin
          addr_d = addr_inc;
          ovf_d  = ovf_q | at_max;
        end else if (!bus.Dec_bar && bus.Inc_bar) begin
          addr_d = addr_dec;
          ovf_d  = ovf_q | at_min;
        end
      end
      BURST: begin
        if (!bus.Lm_bar) begin
          addr_d  = bus.mar_input;
          ovf_d   = 1'b0;
          state_d = IDLE;
          rem_d   = '0;
        end else if (bus.ram_ready) begin
          addr_d = addr_inc;
          ovf_d  = ovf_q | at_max;
          rem_d  = rem_q - BONE;
          if (rem_q == BONE) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge CLK or negedge CLR_bar) begin
    if (!CLR_bar) begin
      addr_q  <= RESET_ADDR;
      state_q <= IDLE;
      rem_q   <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      state_q <= state_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.mar_output  = addr_q;
  assign bus.burst_valid = (state_q == BURST);
  assign bus.burst_busy  = (state_q == BURST);
  assign bus.burst_done  = done_q;
  assign bus.ovf         = ovf_q;

endmodule

// File: tb/tb_mar_burst.sv
// Directed bench for mar_burst: wrap instance (a)
// and saturate instance (s) share clock and reset.
module tb_mar_burst;

  logic CLK = 1'b0;
  logic CLR_bar = 1'b1;
  logic run = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mar_burst_if #(.AW(4), .BL_W(4)) a_if ();
  mar_burst_if #(.AW(4), .BL_W(4)) s_if ();

  mar_burst #(.AW(4), .BL_W(4), .WRAP(1'b1)) u_a (
    .CLK(CLK), .CLR_bar(CLR_bar), .bus(a_if.slave)
  );

  mar_burst #(.AW(4), .BL_W(4), .WRAP(1'b0)) u_s (
    .CLK(CLK), .CLR_bar(CLR_bar), .bus(s_if.slave)
  );

  always begin
    #5;
    if (run) CLK = ~CLK;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_a();
    a_if.Lm_bar = 1'b1; a_if.Inc_bar = 1'b1;
    a_if.Dec_bar = 1'b1; a_if.burst_start = 1'b0;
    a_if.burst_len = 4'h0; a_if.ram_ready = 1'b0;
    a_if.mar_input = 4'h0;
  endtask

  task automatic idle_s();
    s_if.Lm_bar = 1'b1; s_if.Inc_bar = 1'b1;
    s_if.Dec_bar = 1'b1; s_if.burst_start = 1'b0;
    s_if.burst_len = 4'h0; s_if.ram_ready = 1'b0;
    s_if.mar_input = 4'h0;
  endtask

  task automatic load_a(input logic [3:0] v);
    a_if.Lm_bar = 1'b0; a_if.mar_input = v;
    tick();
    a_if.Lm_bar = 1'b1;
  endtask

  task automatic load_s(input logic [3:0] v);
    s_if.Lm_bar = 1'b0; s_if.mar_input = v;
    tick();
    s_if.Lm_bar = 1'b1;
  endtask

  logic [3:0] beats [$];
  logic       pat [4];
  int         nvalid;
  int         ndone;

  initial begin
    idle_a();
    idle_s();
    #2 CLR_bar = 1'b0;
    #1;
    check("rst_addr", 32'(a_if.mar_output), 32'hF);
    check("rst_ovf", 32'(a_if.ovf), 32'h0);
    check("rst_busy", 32'(a_if.burst_busy), 32'h0);
    check("rst_done", 32'(a_if.burst_done), 32'h0);
    #1 CLR_bar = 1'b1;
    run = 1'b1;

    load_a(4'h3);
    check("load3", 32'(a_if.mar_output), 32'h3);

    load_a(4'hE);
    a_if.Inc_bar = 1'b0;
    tick();
    check("inc_E", 32'(a_if.mar_output), 32'hF);
    check("inc_E_ovf", 32'(a_if.ovf), 32'h0);
    tick();
    a_if.Inc_bar = 1'b1;
    check("inc_wrap", 32'(a_if.mar_output), 32'h0);
    check("inc_wrap_ovf", 32'(a_if.ovf), 32'h1);
    load_a(4'h0);
    check("load_clr_ovf", 32'(a_if.ovf), 32'h0);
    a_if.Dec_bar = 1'b0;
    tick();
    a_if.Dec_bar = 1'b1;
    check("dec_wrap", 32'(a_if.mar_output), 32'hF);
    check("dec_wrap_ovf", 32'(a_if.ovf), 32'h1);

    load_s(4'hF);
    s_if.Inc_bar = 1'b0;
    tick();
    s_if.Inc_bar = 1'b1;
    check("sat_inc", 32'(s_if.mar_output), 32'hF);
    check("sat_inc_ovf", 32'(s_if.ovf), 32'h1);
    load_s(4'h0);
    check("sat_load_ovf", 32'(s_if.ovf), 32'h0);
    s_if.Dec_bar = 1'b0;
    tick();
    s_if.Dec_bar = 1'b1;
    check("sat_dec", 32'(s_if.mar_output), 32'h0);
    check("sat_dec_ovf", 32'(s_if.ovf), 32'h1);

    a_if.Inc_bar = 1'b0; a_if.Dec_bar = 1'b0;
    load_a(4'h5);
    tick();
    a_if.Inc_bar = 1'b1; a_if.Dec_bar = 1'b1;
    check("inc_dec_both", 32'(a_if.mar_output), 32'h5);

    pat[0] = 1'b1; pat[1] = 1'b0;
    pat[2] = 1'b1; pat[3] = 1'b1;
    a_if.burst_start = 1'b1; a_if.burst_len = 4'd3;
    tick();
    a_if.burst_start = 1'b0;
    nvalid = 0;
    ndone = 0;
    for (int i = 0; i < 4; i++) begin
      a_if.ram_ready = pat[i];
      if (a_if.burst_valid) nvalid++;
      if (a_if.burst_valid && pat[i])
        beats.push_back(a_if.mar_output);
      tick();
      if (a_if.burst_done) ndone++;
    end
    a_if.ram_ready = 1'b0;
    check("bw_busy_end", 32'(a_if.burst_busy), 32'h0);
    check("bw_final", 32'(a_if.mar_output), 32'h8);
    tick();
    if (a_if.burst_done) ndone++;
    if (a_if.burst_valid) nvalid++;
    check("bw_nvalid", 32'(nvalid), 32'd4);
    check("bw_ndone", 32'(ndone), 32'd1);
    check("bw_nbeats", 32'(beats.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < beats.size())
        check("bw_beat", 32'(beats[i]), 32'(5 + i));
    end

    load_a(4'h2);
    a_if.burst_start = 1'b1; a_if.burst_len = 4'd4;
    tick();
    a_if.burst_start = 1'b0;
    a_if.ram_ready = 1'b1;
    tick();
    check("ab_beat1", 32'(a_if.mar_output), 32'h3);
    check("ab_busy1", 32'(a_if.burst_busy), 32'h1);
    a_if.Lm_bar = 1'b0; a_if.mar_input = 4'hA;
    tick();
    a_if.Lm_bar = 1'b1; a_if.ram_ready = 1'b0;
    check("ab_addr", 32'(a_if.mar_output), 32'hA);
    check("ab_busy", 32'(a_if.burst_busy), 32'h0);
    check("ab_done", 32'(a_if.burst_done), 32'h0);
    tick();
    check("ab_done_late", 32'(a_if.burst_done), 32'h0);
    check("ab_idle_hold", 32'(a_if.mar_output), 32'hA);

    a_if.Inc_bar = 1'b0;
    load_a(4'h7);
    a_if.Inc_bar = 1'b1;
    check("ld_over_inc", 32'(a_if.mar_output), 32'h7);

    a_if.burst_start = 1'b1; a_if.burst_len = 4'd0;
    a_if.Inc_bar = 1'b0;
    tick();
    a_if.burst_start = 1'b0; a_if.Inc_bar = 1'b1;
    check("len0_addr", 32'(a_if.mar_output), 32'h7);
    check("len0_busy", 32'(a_if.burst_busy), 32'h0);

    load_a(4'hF);
    a_if.burst_start = 1'b1; a_if.burst_len = 4'd2;
    a_if.ram_ready = 1'b1;
    tick();
    a_if.burst_start = 1'b0;
    check("wb_first", 32'(a_if.mar_output), 32'hF);
    check("wb_valid", 32'(a_if.burst_valid), 32'h1);
    tick();
    check("wb_second", 32'(a_if.mar_output), 32'h0);
    tick();
    check("wb_end", 32'(a_if.mar_output), 32'h1);
    check("wb_ovf", 32'(a_if.ovf), 32'h1);
    check("wb_done", 32'(a_if.burst_done), 32'h1);
    a_if.burst_start = 1'b1; a_if.burst_len = 4'd1;
    a_if.ram_ready = 1'b0;
    tick();
    a_if.burst_start = 1'b0;
    check("b2b_valid", 32'(a_if.burst_valid), 32'h1);
    check("b2b_done", 32'(a_if.burst_done), 32'h0);
    a_if.ram_ready = 1'b1;
    tick();
    a_if.ram_ready = 1'b0;
    check("b2b_end", 32'(a_if.mar_output), 32'h2);
    check("b2b_done2", 32'(a_if.burst_done), 32'h1);

    a_if.burst_start = 1'b1; a_if.burst_len = 4'd3;
    tick();
    a_if.burst_start = 1'b0;
    check("mr_busy", 32'(a_if.burst_busy), 32'h1);
    #2 CLR_bar = 1'b0;
    #1;
    check("mr_addr", 32'(a_if.mar_output), 32'hF);
    check("mr_busy0", 32'(a_if.burst_busy), 32'h0);
    check("mr_ovf", 32'(a_if.ovf), 32'h0);
    check("mr_done", 32'(a_if.burst_done), 32'h0);
    #1 CLR_bar = 1'b1;
    tick();
    check("mr_after", 32'(a_if.burst_done), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mar_burst.md
# mar_burst

Parametrised memory address register for the SAP datapath: it sits between the W bus and the RAM address input. It keeps the load-from-bus behaviour of the SAP-1 MAR and adds increment/decrement, a selectable wrap or saturate policy, and a sticky overflow flag. A burst engine steps the address through N consecutive locations under a ready handshake from RAM.

## Interface
Parameters:
- AW, 4, address width in bits
- RESET_ADDR, all ones ({AW{1'b1}}), value of mar_output after reset
- BL_W, 4, width of burst_len
- WRAP, 1, 1: modulo-2^AW wrap on inc/dec; 0: saturate at 0 / 2^AW-1

Ports:
- CLK  in  1  clock, all state updates on rising edge
- CLR_bar  in  1  asynchronous active-low reset
- Lm_bar  in  1  active-low load of mar_input
- Inc_bar  in  1  active-low increment, honoured in IDLE only
- Dec_bar  in  1  active-low decrement, honoured in IDLE only
- mar_input  in  AW  address from W bus
- burst_start  in  1  active-high request to start a burst at the current address
- burst_len  in  BL_W  beat count, sampled with burst_start
- ram_ready  in  1  RAM accepts the current beat
- mar_output  out  AW  address to RAM
- burst_valid  out  1  current address is a burst beat
- burst_busy  out  1  burst engine not idle
- burst_done  out  1  one-cycle pulse after the last beat
- ovf  out  1  sticky wrap/saturate flag

## Operation
- Reset (CLR_bar=0, asynchronous): mar_output=RESET_ADDR, state=IDLE, remaining=0, burst_valid=0, burst_busy=0, burst_done=0, ovf=0.
- Two states: IDLE and BURST. All outputs are registered. burst_valid=burst_busy=(state==BURST).
- IDLE priority, highest first: Lm_bar=0 > burst_start=1 > Inc_bar=0 > Dec_bar=0 > hold.
  - Load: mar_output<=mar_input, ovf<=0.
  - burst_start with burst_len!=0: remaining<=burst_len, state<=BURST, address unchanged. The first beat uses the current address.
  - burst_start with burst_len=0: ignored. Lower-priority inc/dec in the same cycle is also suppressed.
  - Inc at 2^AW-1: WRAP=1 gives 0; WRAP=0 holds. Both set ovf.
  - Dec at 0: WRAP=1 gives 2^AW-1; WRAP=0 holds. Both set ovf.
  - Inc_bar and Dec_bar both low: no change.
- BURST:
  - Lm_bar=0 aborts the burst: load mar_input, ovf<=0, state<=IDLE, remaining<=0, no burst_done. Lm_bar has priority over ram_ready.
  - ram_ready=1 and Lm_bar=1: the beat is accepted, the address increments under the WRAP/ovf rules, and remaining decrements.
    - If remaining was 1: state<=IDLE, burst_done<=1.
  - ram_ready=0: hold everything.
  - Inc_bar, Dec_bar and burst_start are ignored.
- burst_done is high for exactly one cycle, then clears. A burst_start in the cycle burst_done is high is accepted, because the state is already IDLE.
- End address of a completed burst: start+L, modulo 2^AW when WRAP=1. With WRAP=0 the address holds at 2^AW-1 once reached, and the remaining beats reissue that address with ovf=1.

## Timing
- Load/inc/dec: mar_output updates at the edge sampling the control, so latency is 1 cycle. This matches SAP-1 MAR load timing.
- burst_start sampled at edge T: burst_valid high from T+1.
- Beat accepted at every edge with burst_valid=1 and ram_ready=1. Zero-wait burst of L beats: burst_valid high for L cycles.
- burst_done high in the cycle after the last accepting edge. burst_busy falls in that same cycle.
- Reset mid-burst: all outputs take reset values immediately, with no clock required. No burst_done is generated.
- ovf changes only on an edge, or clears on reset.

## Test plan
- Reset: assert CLR_bar=0 with no clock -> mar_output=4'hF, ovf=0, burst_busy=0. Release, Lm_bar=0, mar_input=4'h3, one edge -> mar_output=4'h3.
- Inc/dec wrap (WRAP=1): load 4'hE, Inc x2 -> 4'hF then 4'h0 with ovf=1. Load 4'h0 -> ovf=0. Dec -> 4'hF, ovf=1.
- Saturate (WRAP=0): load 4'hF, Inc -> stays 4'hF with ovf=1. Load 4'h0, Dec -> stays 4'h0 with ovf=1.
- Burst with waits: load 4'h5, burst_start, len=3, ram_ready pattern 1,0,1,1 -> beats at 5,6,7. burst_valid high 4 cycles. burst_done pulse once. Final mar_output=4'h8.
- Abort and priority: burst len=4 from 4'h2, after 1 beat assert Lm_bar=0 with mar_input=4'hA and ram_ready=1 -> mar_output=4'hA, state IDLE, no burst_done. In IDLE, Lm_bar=0 with Inc_bar=0 -> load wins.
- Edge cases: burst_len=0 with Inc_bar=0 -> no change. Burst len=2 from 4'hF with WRAP=1 -> beats F,0, end 4'h1, ovf=1. Back-to-back burst_start during burst_done -> new burst_valid next cycle.
